samm_feeder: RTL and testbench
==============================

# samm_feeder

Front-end transmitter for the `samm` systolic matrix multiplier. It accepts two M×M signed matrices, A and B, one row per beat over a valid/ready load port. It then drives the array's skewed input bus: a wavefront of 2M-1 consecutive cycles with the data-valid strobe held high. It blocks new loads until the array signals its result, so it sits directly upstream of `samm`, with `Sa_Data`/`Sa_Dv` wired to the array's `A`/`In_Dv` and `Res_Dv` wired to the array's `Out_Dv`.

## Interface
- `N`, default 8: element width in bits, signed two's complement.
- `M`, default 8: matrix dimension; the array is M×M.
- `Clk` in 1: clock.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `Ld_Valid` in 1: load beat valid.
- `Ld_Ready` out 1: feeder can accept a load beat.
- `Ld_Data` in M*N: one matrix row; element c sits at `[(c+1)*N-1 : c*N]`.
- `Sa_Dv` out 1: skewed stream valid; drives the array's `In_Dv`.
- `Sa_Data` out 2*M*N: skewed stream.
  - Horizontal lane i sits at `[(i+1)*N-1 : i*N]` and feeds PE row i.
  - Vertical lane j sits at `[M*N+(j+1)*N-1 : M*N+j*N]` and feeds PE column j.
- `Res_Dv` in 1: result-valid pulse from the array.
- `Busy` out 1: high in every state except LOAD.

## Operation
- States:
  - LOAD: `Ld_Ready`=1.
  - STREAM: emit 2M-1 slices.
  - WAIT: `Ld_Ready`=0; wait for `Res_Dv`.
- Load phase:
  - A beat is accepted on a clock edge where `Ld_Valid & Ld_Ready`.
  - Beat counter k runs 0..2M-1. Beats 0..M-1 write A rows 0..M-1; beats M..2M-1 write B rows 0..M-1.
  - The edge that accepts beat 2M-1 moves the FSM to STREAM with slice counter t=0 and clears k.
- Stream phase:
  - For slice t in 0..2M-2, horizontal lane i = A[i][t-i] when 0 ≤ t-i < M, else 0.
  - Vertical lane j = B[t-j][j] when 0 ≤ t-j < M, else 0.
  - After slice 2M-2 is registered, the FSM moves to WAIT.
- Wait phase: `Res_Dv` sampled high moves the FSM to LOAD. The `Res_Dv` pulse width is not relevant; the transition is taken on the first high sample.
- `Res_Dv` seen in LOAD or STREAM is ignored.
- `Ld_Valid` outside LOAD is ignored, and no storage is written.
- Element values pass through bit-exact; there is no arithmetic and no sign extension.
- `Sa_Data` is all-zero whenever `Sa_Dv`=0, which matches the array's input gating.

## Timing
- Reset values:
  - FSM=LOAD, k=0, t=0.
  - `Ld_Ready`=1, `Busy`=0, `Sa_Dv`=0, `Sa_Data`=0.
  - The matrix store is cleared.
- `Sa_Dv`/`Sa_Data` are registered.
- Stream timing, with E0 the edge accepting the last load beat:
  - Slice t is presented after edge E0+1+t.
  - `Sa_Dv` is high for exactly 2M-1 consecutive cycles, with no gaps.
  - `Sa_Dv` falls after edge E0+2M.
- `Ld_Ready` and `Busy` are decoded from the FSM state.
  - `Ld_Ready` falls after E0.
  - `Ld_Ready` rises after the edge that samples `Res_Dv`=1 in WAIT.
- Minimum load-to-load turnaround is 2M beats + 2M-1 stream cycles + 1 WAIT cycle (+ array latency).
- Back-to-back load beats are accepted every cycle; a `Ld_Valid` gap simply stalls k.
- Reset asserted mid-stream forces `Sa_Dv`=0 and `Sa_Data`=0 immediately (asynchronously). After release the FSM is in LOAD and a fresh 2M-beat load is required.
- Counter widths:
  - k: $clog2(2M) bits.
  - t: $clog2(2M-1) bits, minimum 1.

## Structure
- Shared package `samm_pkg` holds:
  - the FSM state encoding (LOAD=2'd0, STREAM=2'd1, WAIT=2'd2);
  - lane-offset helper functions (horizontal base 0, vertical base M*N).
- The `samm` top and its testbenches import the same package, so both sides use identical bus slicing.
- One sub-module: `samm_feed_buf`.
  - Holds the 2·M×M element store with row-write port.
  - Its combinational skew-select output takes t and returns the 2*M*N-bit slice.
  - `samm_feeder` keeps the FSM, counters, handshake and output registers.

## Test plan
M=2, N=8, A=[[1,2],[3,4]], B=[[5,6],[7,8]], loaded as beats 16'h0201, 16'h0403, 16'h0605, 16'h0807.
- Nominal stream: after the 4 beats, `Sa_Data` = 32'h00050001, 32'h06070302, 32'h08000400 on three consecutive `Sa_Dv` cycles. With the real array, the final C = [[19,22],[43,50]].
- Handshake stall: insert `Ld_Valid` gaps between beats. The stream is identical, and the first slice appears one cycle after the last accepted beat.
- Wait blocking: hold `Res_Dv`=0 for 20 cycles while driving `Ld_Valid`=1 with 16'hFFFF. `Ld_Ready` stays 0, `Sa_Dv` stays 0, and the store is unchanged. Pulse `Res_Dv`; `Ld_Ready`=1 on the next cycle.
- Signed data: A=[[-1,0],[0,-1]] (16'h00FF, 16'hFF00) with the B above. The slice-0 horizontal lane is 8'hFF, passed unchanged.
- Reset mid-stream: assert `Rst_n`=0 during slice 1. `Sa_Dv` and `Sa_Data` go to 0 without waiting for a clock edge. After release, `Ld_Ready`=1 and a full reload reproduces the nominal stream.
- M=8 sweep: random signed matrices. Every slice must match the reference skew formula for t=0..14, and `Sa_Dv` must be high for exactly 15 cycles.

Source files
------------

// File: rtl/samm_pkg.sv
// Shared definitions for the samm array and its feeder: FSM encoding,
// counter-width helper and bus lane offsets.
package samm_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } feed_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of horizontal lane i (feeds PE row i).
    function automatic int h_lane_lo(input int i, input int n);
        return i * n;
    endfunction

    // LSB of vertical lane j (feeds PE column j); sits above all horizontal lanes.
    function automatic int v_lane_lo(input int j, input int m, input int n);
        return m * n + j * n;
    endfunction

endpackage

// File: rtl/samm_feed_buf.sv
// Element store for A (rows 0..M-1) and B (rows M..2M-1) with a row-write
// port and a combinational skew selector producing one wavefront slice.
module samm_feed_buf
    import samm_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int KW = cnt_w(2 * M),
    parameter int TW = cnt_w(2 * M - 1)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              wr_en,
    input  logic [KW-1:0]     wr_row,
    input  logic [M*N-1:0]    wr_data,
    input  logic [TW-1:0]     t,
    output logic [2*M*N-1:0]  slice
);

    logic [N-1:0] store_q [2*M][M];
    logic [N-1:0] store_d [2*M][M];

    // Row write: one full row lands per accepted beat.
    always_comb begin
        store_d = store_q;
        if (wr_en) begin
            for (int c = 0; c < M; c++) begin
                store_d[wr_row][c] = wr_data[c*N +: N];
            end
        end
    end

    // Store register, cleared on reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int r = 0; r < 2 * M; r++) begin
                for (int c = 0; c < M; c++) begin
                    store_q[r][c] <= '0;
                end
            end
        end else begin
            store_q <= store_d;
        end
    end

    // Skew select: lane i carries A[i][t-i], lane j carries B[t-j][j]; zero outside the diagonal band.
    always_comb begin
        slice = '0;
        for (int i = 0; i < M; i++) begin
            for (int r = 0; r < M; r++) begin
                if (int'(t) == i + r) begin
                    slice[h_lane_lo(i, N) +: N] = store_q[i][r];
                end
            end
        end
        for (int j = 0; j < M; j++) begin
            for (int r = 0; r < M; r++) begin
                if (int'(t) == j + r) begin
                    slice[v_lane_lo(j, M, N) +: N] = store_q[M + r][j];
                end
            end
        end
    end

endmodule

// File: rtl/samm_feeder.sv
// Load/stream/wait sequencer that feeds the samm systolic array its skewed
// A/B wavefront and holds off new loads until the array reports a result.
module samm_feeder
    import samm_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Ld_Valid,
    output logic              Ld_Ready,
    input  logic [M*N-1:0]    Ld_Data,
    output logic              Sa_Dv,
    output logic [2*M*N-1:0]  Sa_Data,
    input  logic              Res_Dv,
    output logic              Busy
);

    localparam int KW = cnt_w(2 * M);
    localparam int TW = cnt_w(2 * M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * M - 1);
    localparam logic [TW-1:0] T_LAST = TW'(2 * M - 2);

    feed_state_e          state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [TW-1:0]        t_q, t_d;
    logic                 sa_dv_q, sa_dv_d;
    logic [2*M*N-1:0]     sa_data_q, sa_data_d;
    logic                 wr_en;
    logic [2*M*N-1:0]     slice;

    samm_feed_buf #(.N(N), .M(M), .KW(KW), .TW(TW)) u_buf (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .wr_en   (wr_en),
        .wr_row  (k_q),
        .wr_data (Ld_Data),
        .t       (t_q),
        .slice   (slice)
    );

    // Next-state, counter and output-register decode; outputs idle at zero outside STREAM.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        t_d       = t_q;
        sa_dv_d   = 1'b0;
        sa_data_d = '0;
        wr_en     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (Ld_Valid) begin
                    wr_en = 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        t_d     = '0;
                        state_d = ST_STREAM;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                sa_dv_d   = 1'b1;
                sa_data_d = slice;
                if (t_q == T_LAST) begin
                    t_d     = '0;
                    state_d = ST_WAIT;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (Res_Dv) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, counters and registered stream outputs; reset clears the stream at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_LOAD;
            k_q       <= '0;
            t_q       <= '0;
            sa_dv_q   <= 1'b0;
            sa_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            t_q       <= t_d;
            sa_dv_q   <= sa_dv_d;
            sa_data_q <= sa_data_d;
        end
    end

    assign Ld_Ready = (state_q == ST_LOAD);
    assign Busy     = (state_q != ST_LOAD);
    assign Sa_Dv    = sa_dv_q;
    assign Sa_Data  = sa_data_q;

endmodule

// File: tb/tb_samm_feeder.sv
// Scoreboard bench for samm_feeder: an M=2 instance for directed cases and
// an M=8 instance for random signed sweeps.
module tb_samm_feeder;
    import samm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // M=2 instance
    logic         rst2_n, ld_valid2, ld_ready2, sa_dv2, res_dv2, busy2;
    logic [15:0]  ld_data2;
    logic [31:0]  sa_data2;
    // M=8 instance
    logic         rst8_n, ld_valid8, ld_ready8, sa_dv8, res_dv8, busy8;
    logic [63:0]  ld_data8;
    logic [127:0] sa_data8;

    samm_feeder #(.N(8), .M(2)) dut2 (
        .Clk(clk), .Rst_n(rst2_n), .Ld_Valid(ld_valid2), .Ld_Ready(ld_ready2),
        .Ld_Data(ld_data2), .Sa_Dv(sa_dv2), .Sa_Data(sa_data2),
        .Res_Dv(res_dv2), .Busy(busy2)
    );

    samm_feeder #(.N(8), .M(8)) dut8 (
        .Clk(clk), .Rst_n(rst8_n), .Ld_Valid(ld_valid8), .Ld_Ready(ld_ready8),
        .Ld_Data(ld_data8), .Sa_Dv(sa_dv8), .Sa_Data(sa_data8),
        .Res_Dv(res_dv8), .Busy(busy8)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [127:0] exp2_q[$];
    logic [127:0] exp8_q[$];
    int run2 = 0;
    int run8 = 0;

    logic [63:0] nom_beats = {16'h0807, 16'h0605, 16'h0403, 16'h0201};
    logic [95:0] nom_exp   = {32'h08000400, 32'h06070302, 32'h00050001};
    logic [63:0] sgn_beats = {16'h0807, 16'h0605, 16'hFF00, 16'h00FF};
    logic [95:0] sgn_exp   = {32'h0800FF00, 32'h06070000, 32'h000500FF};

    logic signed [7:0] a8 [8][8];
    logic signed [7:0] b8 [8][8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_note(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected drained stream", name);
    endtask

    // M=2 monitor: pops one expected slice per Sa_Dv cycle, checks idle zero and run length.
    always @(negedge clk) begin
        if (!rst2_n) begin
            run2 = 0;
        end else if (sa_dv2) begin
            run2++;
            if (exp2_q.size() == 0) begin
                n_total++;
                $display("FAIL m2 unexpected slice: got %0h expected none", sa_data2);
            end else begin
                chk("m2 slice", 128'(sa_data2), exp2_q.pop_front());
            end
        end else begin
            chk("m2 idle data zero", 128'(sa_data2), 128'(0));
            if (run2 != 0) begin
                chk("m2 dv run length", 128'(run2), 128'(3));
                run2 = 0;
            end
        end
    end

    // M=8 monitor, same duties.
    always @(negedge clk) begin
        if (!rst8_n) begin
            run8 = 0;
        end else if (sa_dv8) begin
            run8++;
            if (exp8_q.size() == 0) begin
                n_total++;
                $display("FAIL m8 unexpected slice: got %0h expected none", sa_data8);
            end else begin
                chk("m8 slice", sa_data8, exp8_q.pop_front());
            end
        end else begin
            chk("m8 idle data zero", sa_data8, 128'(0));
            if (run8 != 0) begin
                chk("m8 dv run length", 128'(run8), 128'(15));
                run8 = 0;
            end
        end
    end

    // Drives 4 beats (gap idle cycles between beats), queues expected slices, checks start latency.
    task automatic load2(input logic [63:0] beats, input logic [95:0] exp, input int gap);
        for (int b = 0; b < 4; b++) begin
            if (b != 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    ld_valid2 = 1'b0;
                end
            end
            @(negedge clk);
            ld_valid2 = 1'b1;
            ld_data2  = beats[b*16 +: 16];
        end
        for (int s = 0; s < 3; s++) exp2_q.push_back(128'(exp[s*32 +: 32]));
        @(negedge clk);
        chk("m2 ready low after last beat", 128'(ld_ready2), 128'(0));
        chk("m2 dv low one cycle after E0", 128'(sa_dv2), 128'(0));
        ld_valid2 = 1'b0;
        @(negedge clk);
        chk("m2 first slice latency", 128'(sa_dv2), 128'(1));
    endtask

    task automatic drain2();
        for (int c = 0; c < 12 && exp2_q.size() != 0; c++) @(negedge clk);
        if (exp2_q.size() != 0) begin
            fail_note("m2 drain");
            exp2_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("m2 busy in wait", 128'(busy2), 128'(1));
        chk("m2 ready low in wait", 128'(ld_ready2), 128'(0));
    endtask

    task automatic release2();
        @(negedge clk);
        res_dv2 = 1'b1;
        @(negedge clk);
        res_dv2 = 1'b0;
        chk("m2 ready after res_dv", 128'(ld_ready2), 128'(1));
        chk("m2 busy cleared", 128'(busy2), 128'(0));
    endtask

    task automatic sweep8(input int gap);
        logic [63:0]  beat;
        logic [127:0] s;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 8; c++) begin
                a8[i][c] = 8'($urandom);
                b8[i][c] = 8'($urandom);
            end
        end
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                beat[c*8 +: 8] = (r < 8) ? a8[r][c] : b8[r-8][c];
            end
            if (r != 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    ld_valid8 = 1'b0;
                end
            end
            @(negedge clk);
            ld_valid8 = 1'b1;
            ld_data8  = beat;
        end
        for (int t = 0; t < 15; t++) begin
            s = '0;
            for (int i = 0; i < 8; i++) begin
                if (t - i >= 0 && t - i < 8) s[i*8 +: 8] = a8[i][t-i];
            end
            for (int j = 0; j < 8; j++) begin
                if (t - j >= 0 && t - j < 8) s[64 + j*8 +: 8] = b8[t-j][j];
            end
            exp8_q.push_back(s);
        end
        @(negedge clk);
        ld_valid8 = 1'b0;
        chk("m8 dv low one cycle after E0", 128'(sa_dv8), 128'(0));
        @(negedge clk);
        chk("m8 first slice latency", 128'(sa_dv8), 128'(1));
        for (int c = 0; c < 30 && exp8_q.size() != 0; c++) @(negedge clk);
        if (exp8_q.size() != 0) begin
            fail_note("m8 drain");
            exp8_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("m8 ready low in wait", 128'(ld_ready8), 128'(0));
        res_dv8 = 1'b1;
        @(negedge clk);
        res_dv8 = 1'b0;
        chk("m8 ready after res_dv", 128'(ld_ready8), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst2_n = 1'b0; ld_valid2 = 1'b0; ld_data2 = '0; res_dv2 = 1'b0;
        rst8_n = 1'b0; ld_valid8 = 1'b0; ld_data8 = '0; res_dv8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("m2 reset ready", 128'(ld_ready2), 128'(1));
        chk("m2 reset busy", 128'(busy2), 128'(0));
        chk("m2 reset dv", 128'(sa_dv2), 128'(0));
        chk("m2 reset data", 128'(sa_data2), 128'(0));
        chk("m8 reset ready", 128'(ld_ready8), 128'(1));
        rst2_n = 1'b1;
        rst8_n = 1'b1;

        // Nominal back-to-back load
        load2(nom_beats, nom_exp, 0);
        drain2();

        // Wait blocking: beats offered while waiting must be ignored
        ld_valid2 = 1'b1;
        ld_data2  = 16'hFFFF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("m2 ready held low in wait", 128'(ld_ready2), 128'(0));
        end
        ld_valid2 = 1'b0;
        release2();

        // Stalled load, with a stray Res_Dv while loading
        res_dv2 = 1'b1;
        load2(nom_beats, nom_exp, 2);
        res_dv2 = 1'b0;
        drain2();
        release2();

        // Signed data passes bit-exact
        load2(sgn_beats, sgn_exp, 1);
        drain2();
        release2();

        // Reset during slice 1
        load2(nom_beats, nom_exp, 0);
        @(posedge clk);
        #2;
        rst2_n = 1'b0;
        #1;
        chk("m2 async reset dv", 128'(sa_dv2), 128'(0));
        chk("m2 async reset data", 128'(sa_data2), 128'(0));
        exp2_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        chk("m2 ready after reset", 128'(ld_ready2), 128'(1));
        chk("m2 busy after reset", 128'(busy2), 128'(0));
        load2(nom_beats, nom_exp, 0);
        drain2();
        release2();

        // M=8 random signed sweeps
        sweep8(0);
        sweep8(1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
